expr_string_gen: RTL and testbench
==================================

Name: expr_string_gen

Overview:
- Transmitter side of the ASCII arithmetic-expression stream: serialises a latched list of single-digit operands and operators into bytes.
- Output grammar is digit ((+|*) digit)*, e.g. "3+4*9".
- One byte per accepted handshake, driven into the downstream expression checker / UART path.
- Loaded by a start pulse; reports completion and rejects malformed loads.

Parameters:
- MAX_TERMS, 8, maximum number of operand digits per expression (2..15).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  reset, asynchronous, active-high; forces idle and clears all outputs.
- start  in  1  load request; sampled only in IDLE.
- digits  in  4*MAX_TERMS  BCD operands; term k in bits [4k+3:4k], term 0 emitted first.
- ops  in  MAX_TERMS-1  operator k sits between term k and term k+1; 0='+', 1='*'.
- nterms  in  4  number of terms to emit (1..MAX_TERMS).
- out_ready  in  1  downstream accepts out_char this cycle.
- out_valid  out  1  out_char holds a valid byte.
- out_char  out  8  ASCII byte.
- out_last  out  1  high with the final digit of the expression.
- busy  out  1  high from the cycle after an accepted start until the final handshake completes.
- done  out  1  one-cycle pulse after the final byte is accepted.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: asserting clr forces IDLE immediately, mid-operation included. While clr is high, out_valid, out_char, out_last, busy, done and err are all 0. After clr deasserts, the block sits idle until a new start.
- States:
  - IDLE: waiting for start.
  - DIG: presenting a digit.
  - OP: presenting an operator.
  - FIN: done pulse cycle, then back to IDLE.
- Start acceptance, in IDLE with start=1:
  - Accepted only if 1 <= nterms <= MAX_TERMS and every digit field below nterms is <= 9.
  - Accepted: latch digits, ops and nterms; clear term index k=0; next cycle go to DIG with out_valid=1 and busy=1. Start-to-first-byte latency is 1 cycle.
  - Rejected: err=1 for exactly one cycle; stay in IDLE; nothing latched.
- start outside IDLE is ignored (no err). Input changes after acceptance have no effect.
- Character encoding:
  - Digit byte = 8'h30 + d, so '0'..'9' = 8'h30..8'h39.
  - '+' = 8'h2B, '*' = 8'h2A.
- Handshake:
  - A byte transfers on any posedge with out_valid && out_ready.
  - While out_valid && !out_ready, out_char, out_last and state hold stable.
  - out_valid never drops without a transfer.
- Transitions on transfer:
  - DIG with k < nterms-1: go to OP presenting ops[k].
  - OP: k <= k+1; go to DIG presenting digit k.
  - DIG with k == nterms-1 (out_last=1): go to FIN. out_valid=0 and busy=0 next cycle; done=1 for that one cycle.
  - FIN: go to IDLE on the following cycle. start is not accepted during FIN.
- out_last is 1 only in DIG with k == nterms-1; it is 0 on operators.
- Streaming rate:
  - With out_ready tied high, an n-term expression occupies exactly 2n-1 consecutive out_valid cycles.
  - A back-to-back start is earliest in the IDLE cycle after FIN.
- nterms=1 emits a single digit with out_last=1 on the first byte.
- Invariant: every completed output sequence satisfies digit((+|*)digit)*. Operators are never emitted first or last, and no two digits or two operators are ever adjacent.

Test Plan:
- Load nterms=3, digits={9,4,3} (term0=3), ops=2'b10, out_ready=1:
  - out_char = 8'h33, 8'h2B, 8'h34, 8'h2A, 8'h39 on 5 consecutive cycles.
  - out_last only on 8'h39; done the cycle after.
- Same load with out_ready toggled 0/1 every cycle: identical 5-byte sequence, each byte held stable while out_ready=0, total 10 cycles of out_valid.
- Rejected loads: nterms=0, nterms=MAX_TERMS+1, and a digit field = 4'hA each give one err pulse; out_valid and busy stay 0.
- nterms=1, digit 0: single byte 8'h30 with out_last=1, then done pulse.
- Assert clr while presenting the second byte of a 4-term load: all outputs 0 during clr; no further bytes after release; a new start is accepted normally and emits from term 0.
- Pulse start during busy with different operands: ignored; the original stream completes unchanged and no err pulse occurs.

Source files
------------

// File: rtl/expr_string_gen.sv
`default_nettype none
// ============================================================================
// Module   : expr_string_gen
// Purpose  : Serialises a latched list of BCD operands and +/* operators into
//            an ASCII expression stream "d(op d)*", one byte per handshake.
// Revision : 1.0 - initial release
// ============================================================================
module expr_string_gen #(
    parameter int MAX_TERMS = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic [4*MAX_TERMS-1:0]   digits,
    input  logic [MAX_TERMS-2:0]     ops,
    input  logic [3:0]               nterms,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_char,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIG  = 2'd1,
        S_OP   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [4*MAX_TERMS-1:0]   digits_q, digits_d;
    logic [MAX_TERMS-2:0]     ops_q, ops_d;
    logic [3:0]               nterms_q, nterms_d;
    logic [3:0]               k_q, k_d;
    logic                     err_q, err_d;

    logic                     load_ok;
    logic [3:0]               cur_digit;
    logic                     cur_op;
    logic                     is_last;
    logic                     xfer;

    // A load is legal when the term count is in range and every used field is BCD
    always_comb begin
        load_ok = (nterms != 4'd0) && (nterms <= 4'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((4'(i) < nterms) && (digits[4*i +: 4] > 4'd9)) begin
                load_ok = 1'b0;
            end
        end
    end

    // Select the digit and operator addressed by the current term index
    always_comb begin
        cur_digit = 4'd0;
        cur_op    = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (k_q == 4'(i)) begin
                cur_digit = digits_q[4*i +: 4];
            end
        end
        for (int j = 0; j < MAX_TERMS - 1; j++) begin
            if (k_q == 4'(j)) begin
                cur_op = ops_q[j];
            end
        end
    end

    assign is_last = (k_q == (nterms_q - 4'd1));
    assign xfer    = out_valid && out_ready;

    // State and latched operand registers; clr returns everything to idle at once
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            ops_q    <= '0;
            nterms_q <= 4'd0;
            k_q      <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            nterms_q <= nterms_d;
            k_q      <= k_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: load/reject in idle, advance the term index on each operator transfer
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        nterms_d = nterms_q;
        k_d      = k_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (load_ok) begin
                        digits_d = digits;
                        ops_d    = ops;
                        nterms_d = nterms;
                        k_d      = 4'd0;
                        state_d  = S_DIG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DIG: begin
                if (xfer) begin
                    state_d = is_last ? S_FIN : S_OP;
                end
            end
            S_OP: begin
                if (xfer) begin
                    k_d     = k_q + 4'd1;
                    state_d = S_DIG;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state, so they hold while the handshake stalls
    always_comb begin
        out_valid = (state_q == S_DIG) || (state_q == S_OP);
        out_last  = (state_q == S_DIG) && is_last;
        busy      = out_valid;
        done      = (state_q == S_FIN);
        err       = err_q;
        out_char  = 8'h00;
        if (state_q == S_DIG) begin
            out_char = 8'h30 + {4'h0, cur_digit};
        end else if (state_q == S_OP) begin
            out_char = cur_op ? 8'h2A : 8'h2B;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expr_string_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_string_gen
// Purpose  : Self-checking bench for expr_string_gen: vector table, directed
//            corner sequences and randomized loads against an expression model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_string_gen;

    localparam int MAX_TERMS = 8;

    logic                   clk;
    logic                   clr;
    logic                   start;
    logic [4*MAX_TERMS-1:0] digits;
    logic [MAX_TERMS-2:0]   ops;
    logic [3:0]             nterms;
    logic                   out_ready;
    logic                   out_valid;
    logic [7:0]             out_char;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    int tests = 0;
    int fails = 0;

    expr_string_gen #(.MAX_TERMS(MAX_TERMS)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .digits    (digits),
        .ops       (ops),
        .nterms    (nterms),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  nt;
        logic [31:0] dg;
        logic [6:0]  op;
        int          mode;      // 0: ready high, 1: ready toggles starting low, 2: random
        logic        exp_err;
        int          exp_vcyc;  // out_valid cycles expected (0 for rejected loads)
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: load legality from the rules, independent of the DUT
    function automatic bit model_ok(input logic [3:0] nt, input logic [31:0] dg);
        if (nt < 1 || nt > MAX_TERMS) return 1'b0;
        for (int m = 0; m < int'(nt); m++) begin
            if (((dg >> (4*m)) & 32'hF) > 32'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reject(input string nm, input logic [3:0] nt, input logic [31:0] dg, input logic [6:0] op);
        start = 1'b1; nterms = nt; digits = dg; ops = op; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, " err pulse"}, {31'd0, err}, 32'd1);
        chk({nm, " valid stays low"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " busy stays low"}, {31'd0, busy}, 32'd0);
        tick();
        chk({nm, " err one cycle"}, {31'd0, err}, 32'd0);
        chk({nm, " still idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Drives one accepted load and checks every byte against the model string.
    // inject >= 0 pulses start with other operands at that stream cycle.
    task automatic do_stream(input string nm, input logic [3:0] nt, input logic [31:0] dg,
                             input logic [6:0] op, input int mode, input int inject,
                             output int vcyc);
        byte unsigned exp_q[$];
        int  idx;
        int  cyc;
        logic rdy;
        logic prev_hold;
        logic [7:0] prev_char;
        for (int m = 0; m < int'(nt); m++) begin
            exp_q.push_back(8'(8'h30 + ((dg >> (4*m)) & 32'hF)));
            if (m < int'(nt) - 1) exp_q.push_back(op[m] ? 8'h2A : 8'h2B);
        end
        start = 1'b1; nterms = nt; digits = dg; ops = op; out_ready = 1'b0;
        tick();
        start = 1'b0;
        digits = $urandom; ops = 7'($urandom); nterms = 4'($urandom);
        idx = 0; cyc = 0; vcyc = 0; prev_hold = 1'b0; prev_char = 8'h00;
        while (idx < exp_q.size() && cyc < 200) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2) == 1;
            else                rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            start = (cyc == inject);
            if (cyc == inject) begin
                digits = 32'h11111111; ops = 7'h7F; nterms = 4'd2;
            end
            chk({nm, " valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, " busy"}, {31'd0, busy}, 32'd1);
            chk({nm, " no err"}, {31'd0, err}, 32'd0);
            chk({nm, " char"}, {24'd0, out_char}, {24'd0, exp_q[idx]});
            chk({nm, " last"}, {31'd0, out_last}, (idx == exp_q.size() - 1) ? 32'd1 : 32'd0);
            if (prev_hold) chk({nm, " hold stable"}, {24'd0, out_char}, {24'd0, prev_char});
            vcyc++;
            if (rdy) idx++;
            prev_hold = !rdy;
            prev_char = out_char;
            tick();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) chk({nm, " stream timeout"}, 32'd1, 32'd0);
        out_ready = 1'b0;
        chk({nm, " done pulse"}, {31'd0, done}, 32'd1);
        chk({nm, " valid low at done"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " busy low at done"}, {31'd0, busy}, 32'd0);
        chk({nm, " no err at done"}, {31'd0, err}, 32'd0);
        tick();
        chk({nm, " done one cycle"}, {31'd0, done}, 32'd0);
        chk({nm, " idle after fin"}, {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int vc;
        logic [3:0]  rnt;
        logic [31:0] rdg;
        logic [6:0]  rop;

        vecs[0] = '{4'd3, 32'h00000943, 7'b0000010, 0, 1'b0, 5};
        vecs[1] = '{4'd3, 32'h00000943, 7'b0000010, 1, 1'b0, 10};
        vecs[2] = '{4'd1, 32'h00000000, 7'b0000000, 0, 1'b0, 1};
        vecs[3] = '{4'd0, 32'h00000123, 7'b0000000, 0, 1'b1, 0};
        vecs[4] = '{4'd9, 32'h00000000, 7'b0000000, 0, 1'b1, 0};
        vecs[5] = '{4'd3, 32'h000000A3, 7'b0000000, 0, 1'b1, 0};
        vecs[6] = '{4'd8, 32'h98765432, 7'b1010101, 0, 1'b0, 15};
        vecs[7] = '{4'd2, 32'hFFFFFF09, 7'b1111111, 0, 1'b0, 3};

        clr = 1'b1; start = 1'b0; digits = '0; ops = '0; nterms = 4'd0; out_ready = 1'b0;
        tick();
        chk("reset valid", {31'd0, out_valid}, 32'd0);
        chk("reset char", {24'd0, out_char}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        clr = 1'b0;
        tick();
        chk("idle after reset", {31'd0, out_valid}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_err) begin
                do_reject($sformatf("vec%0d", v), vecs[v].nt, vecs[v].dg, vecs[v].op);
            end else begin
                do_stream($sformatf("vec%0d", v), vecs[v].nt, vecs[v].dg, vecs[v].op,
                          vecs[v].mode, -1, vc);
                chk($sformatf("vec%0d valid cycles", v), vc, vecs[v].exp_vcyc);
            end
        end

        // clr while the second byte of a 4-term load is on the bus
        start = 1'b1; nterms = 4'd4; digits = 32'h00005678; ops = 7'b0000101; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("clr-test first byte", {24'd0, out_char}, 32'h38);
        tick();
        chk("clr-test second byte", {24'd0, out_char}, 32'h2A);
        clr = 1'b1;
        #1;
        chk("clr valid", {31'd0, out_valid}, 32'd0);
        chk("clr char", {24'd0, out_char}, 32'd0);
        chk("clr last", {31'd0, out_last}, 32'd0);
        chk("clr busy", {31'd0, busy}, 32'd0);
        tick();
        chk("clr held valid", {31'd0, out_valid}, 32'd0);
        chk("clr held done", {31'd0, done}, 32'd0);
        clr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("post-clr silent", {31'd0, out_valid}, 32'd0);
            chk("post-clr not busy", {31'd0, busy}, 32'd0);
        end
        do_stream("after clr", 4'd4, 32'h00001234, 7'b0000110, 0, -1, vc);
        chk("after clr valid cycles", vc, 7);

        // start pulsed while busy must be ignored
        do_stream("busy start", 4'd3, 32'h00000567, 7'b0000001, 0, 2, vc);
        chk("busy start valid cycles", vc, 5);

        // randomized loads against the model
        for (int r = 0; r < 40; r++) begin
            rnt = 4'($urandom_range(0, 9));
            rdg = 32'd0;
            for (int m = 0; m < MAX_TERMS; m++) begin
                if ($urandom_range(0, 9) == 0) rdg[4*m +: 4] = 4'($urandom_range(10, 15));
                else                           rdg[4*m +: 4] = 4'($urandom_range(0, 9));
            end
            rop = 7'($urandom);
            if (model_ok(rnt, rdg)) begin
                do_stream($sformatf("rand%0d", r), rnt, rdg, rop, 2, -1, vc);
                chk($sformatf("rand%0d min cycles", r), (vc >= 2*int'(rnt) - 1) ? 32'd1 : 32'd0, 32'd1);
            end else begin
                do_reject($sformatf("rand%0d", r), rnt, rdg, rop);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
